// File: rtl/vga_point_renderer.sv
// 640x480 VGA timing generator that draws a square marker over a background colour.
// Position, size and colours are shadowed at each frame boundary so a frame never tears.
module vga_point_renderer #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int MAX_HALF  = 15
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [10:0] posx,
    input  logic [10:0] posy,
    input  logic [10:0] posz,
    input  logic [11:0] background,
    input  logic [11:0] point,
    input  logic        sw_ctrl,
    input  logic [11:0] sw,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_FIRST = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [10:0] HALF_MAX = 11'(MAX_HALF);

    logic [DIV_W-1:0] r_div_cnt;
    logic [10:0]      r_hcnt;
    logic [10:0]      r_vcnt;
    logic [10:0]      r_sx;
    logic [10:0]      r_sy;
    logic [10:0]      r_shalf;
    logic [11:0]      r_sbg;
    logic [11:0]      r_spt;
    logic [11:0]      r_ssw;
    logic             r_sctl;
    logic [11:0]      r_rgb;
    logic             r_hs;
    logic             r_vs;
    logic             r_frame_start;

    logic             w_pix_en;
    logic             w_h_wrap;
    logic             w_frame_end;
    logic [10:0]      w_half_next;
    logic [11:0]      w_dx_diff;
    logic [11:0]      w_dy_diff;
    logic [11:0]      w_dx;
    logic [11:0]      w_dy;
    logic             w_hit;
    logic             w_visible;
    logic [11:0]      w_rgb;
    logic             w_hs;
    logic             w_vs;

    assign w_pix_en    = (r_div_cnt == DIV_LAST);
    assign w_h_wrap    = w_pix_en && (r_hcnt == H_LAST);
    assign w_frame_end = w_h_wrap && (r_vcnt == V_LAST);
    assign w_half_next = (posz > HALF_MAX) ? HALF_MAX : posz;

    // Zero-extended 12-bit differences cover -2047..2047, so the magnitude never wraps.
    assign w_dx_diff = {1'b0, r_hcnt} - {1'b0, r_sx};
    assign w_dy_diff = {1'b0, r_vcnt} - {1'b0, r_sy};
    assign w_dx      = w_dx_diff[11] ? (12'd0 - w_dx_diff) : w_dx_diff;
    assign w_dy      = w_dy_diff[11] ? (12'd0 - w_dy_diff) : w_dy_diff;
    assign w_hit     = (w_dx <= {1'b0, r_shalf}) && (w_dy <= {1'b0, r_shalf});

    assign w_visible = (r_hcnt < H_VIS) && (r_vcnt < V_VIS);
    assign w_rgb     = !w_visible ? 12'h000 : (w_hit ? (r_sctl ? r_ssw : r_spt) : r_sbg);
    assign w_hs      = !((r_hcnt >= HS_FIRST) && (r_hcnt <= HS_LAST));
    assign w_vs      = !((r_vcnt >= VS_FIRST) && (r_vcnt <= VS_LAST));

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_div_cnt     <= '0;
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_sx          <= '0;
            r_sy          <= '0;
            r_shalf       <= '0;
            r_sbg         <= 12'h0c3;
            r_spt         <= 12'hfff;
            r_sctl        <= 1'b1;
            r_ssw         <= '0;
            r_rgb         <= '0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_div_cnt     <= w_pix_en ? '0 : r_div_cnt + 1'b1;
            r_frame_start <= w_frame_end;
            if (w_pix_en) begin
                r_hcnt <= w_h_wrap ? '0 : r_hcnt + 11'd1;
                if (w_h_wrap) begin
                    r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 11'd1;
                end
                r_rgb <= w_rgb;
                r_hs  <= w_hs;
                r_vs  <= w_vs;
            end
            // The wrap pixel is blanking, so new shadows only matter from (0,0).
            if (w_frame_end) begin
                r_sx    <= posx;
                r_sy    <= posy;
                r_shalf <= w_half_next;
                r_sbg   <= background;
                r_spt   <= point;
                r_sctl  <= sw_ctrl;
                r_ssw   <= sw;
            end
        end
    end

    assign vga_r       = r_rgb[11:8];
    assign vga_g       = r_rgb[7:4];
    assign vga_b       = r_rgb[3:0];
    assign vga_hs      = r_hs;
    assign vga_vs      = r_vs;
    assign frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_point_renderer.sv
// Bench for vga_point_renderer on a shrunken raster: a frame-level model predicts every
// output cycle, and a table of hand-computed pixels pins the model.
module tb_vga_point_renderer;
    localparam int CD   = 4;
    localparam int HV   = 16;
    localparam int HFP  = 2;
    localparam int HS   = 3;
    localparam int HBP  = 2;
    localparam int VV   = 12;
    localparam int VFP  = 1;
    localparam int VS   = 2;
    localparam int VBP  = 1;
    localparam int MAXH = 3;
    localparam int HT    = HV + HFP + HS + HBP;  // 23
    localparam int VT    = VV + VFP + VS + VBP;  // 16
    localparam int FRAME = HT * VT;              // 368 pixels
    localparam int FC    = FRAME * CD;           // 1472 HCLK per frame

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [10:0] posx = '0;
    logic [10:0] posy = '0;
    logic [10:0] posz = '0;
    logic [11:0] background = '0;
    logic [11:0] point = '0;
    logic        sw_ctrl = 1'b0;
    logic [11:0] sw = '0;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        frame_start;

    vga_point_renderer #(
        .CLK_DIV(CD), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .MAX_HALF(MAXH)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .posx(posx), .posy(posy), .posz(posz),
        .background(background), .point(point), .sw_ctrl(sw_ctrl), .sw(sw),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .frame_start(frame_start)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        int          x;
        int          y;
        int          half;
        logic [11:0] bg;
        logic [11:0] pt;
        logic [11:0] swv;
        logic        ctl;
    } shadow_t;

    typedef struct {
        int          ep;
        int          f;
        int          h;
        int          v;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } lit_t;

    int      tests = 0;
    int      fails = 0;
    shadow_t sh[16];
    lit_t    lits[$];
    int      lit_hit[64];
    int      n = 0;
    int      epoch = -1;
    bit      in_reset = 0;
    bit      started = 0;
    bit      m_valid = 0;
    int      m_f = 0;
    int      m_h = 0;
    int      m_v = 0;
    longint  gc = 0;
    longint  last_fs = -1;

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    function automatic void add_lit(input int ep, input int f, input int h, input int v,
                                    input logic [11:0] rgb, input logic hs, input logic vs);
        lit_t l;
        l.ep = ep; l.f = f; l.h = h; l.v = v; l.rgb = rgb; l.hs = hs; l.vs = vs;
        lits.push_back(l);
    endfunction

    // Model: n counts edges since reset release; output after edge n shows pixel n/CD-1.
    always @(posedge HCLK) begin
        gc++;
        if (HRESET) begin
            if (!in_reset) epoch++;
            in_reset = 1;
            started  = 1;
            n        = 0;
            last_fs  = -1;
            sh[0].x = 0; sh[0].y = 0; sh[0].half = 0;
            sh[0].bg = 12'h0c3; sh[0].pt = 12'hfff; sh[0].swv = 12'h000; sh[0].ctl = 1'b1;
        end else begin
            in_reset = 0;
            n++;
            if (n % FC == 0 && n / FC < 16) begin
                sh[n / FC].x    = int'(posx);
                sh[n / FC].y    = int'(posy);
                sh[n / FC].half = (int'(posz) > MAXH) ? MAXH : int'(posz);
                sh[n / FC].bg   = background;
                sh[n / FC].pt   = point;
                sh[n / FC].swv  = sw;
                sh[n / FC].ctl  = sw_ctrl;
            end
        end
        if (n >= CD) begin
            m_valid = 1;
            m_f = (n / CD - 1) / FRAME;
            m_h = ((n / CD - 1) % FRAME) % HT;
            m_v = ((n / CD - 1) % FRAME) / HT;
        end else begin
            m_valid = 0;
        end
    end

    always @(negedge HCLK) begin
        logic [11:0] e_rgb;
        logic        e_hs;
        logic        e_vs;
        logic        e_fs;
        logic [11:0] a_rgb;
        a_rgb = {vga_r, vga_g, vga_b};
        if (started) begin
            e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1;
            if (m_valid && m_f < 16) begin
                shadow_t s;
                s = sh[m_f];
                if (m_h < HV && m_v < VV) begin
                    if (iabs(m_h - s.x) <= s.half && iabs(m_v - s.y) <= s.half)
                        e_rgb = s.ctl ? s.swv : s.pt;
                    else
                        e_rgb = s.bg;
                end
                e_hs = !(m_h >= HV + HFP && m_h < HV + HFP + HS);
                e_vs = !(m_v >= VV + VFP && m_v < VV + VFP + VS);
            end
            e_fs = (n > 0) && (n % FC == 0);
            tests++;
            if (a_rgb !== e_rgb || vga_hs !== e_hs || vga_vs !== e_vs || frame_start !== e_fs) begin
                fails++;
                if (fails < 30)
                    $display("FAIL cycle n=%0d pix(%0d,%0d) f%0d: got rgb=%h hs=%b vs=%b fs=%b, want rgb=%h hs=%b vs=%b fs=%b",
                             n, m_h, m_v, m_f, a_rgb, vga_hs, vga_vs, frame_start, e_rgb, e_hs, e_vs, e_fs);
            end
            if (m_valid && n % CD == 0) begin
                foreach (lits[i]) begin
                    if (lits[i].ep == epoch && lits[i].f == m_f && lits[i].h == m_h && lits[i].v == m_v) begin
                        lit_hit[i]++;
                        tests++;
                        if (a_rgb !== lits[i].rgb || vga_hs !== lits[i].hs || vga_vs !== lits[i].vs) begin
                            fails++;
                            $display("FAIL pixel e%0d f%0d (%0d,%0d): got rgb=%h hs=%b vs=%b, want rgb=%h hs=%b vs=%b",
                                     epoch, m_f, m_h, m_v, a_rgb, vga_hs, vga_vs,
                                     lits[i].rgb, lits[i].hs, lits[i].vs);
                        end
                    end
                end
            end
            if (frame_start === 1'b1) begin
                if (last_fs >= 0) begin
                    tests++;
                    if (gc - last_fs != 1472) begin
                        fails++;
                        $display("FAIL frame_start period: got %0d, want 1472", gc - last_fs);
                    end
                end
                last_fs = gc;
            end
        end
    end

    task automatic wait_pix(input int ep, input int f, input int h, input int v);
        int budget;
        budget = 0;
        while (!(epoch == ep && m_valid && m_f == f && m_h == h && m_v == v) && budget < 4000) begin
            @(negedge HCLK);
            budget++;
        end
        if (budget >= 4000) begin
            fails++;
            $display("FAIL wait_pix e%0d f%0d (%0d,%0d): timed out, want reached", ep, f, h, v);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge HCLK);
        HRESET = 1'b1;
        repeat (cycles) @(negedge HCLK);
        HRESET = 1'b0;
    endtask

    initial begin
        // Reset shadows: (0,0) is a hit drawn in ssw=000, everything else background 0c3.
        add_lit(0, 0, 0, 0, 12'h000, 1, 1);
        add_lit(0, 0, 1, 0, 12'h0c3, 1, 1);
        add_lit(0, 0, 17, 0, 12'h000, 1, 1);
        add_lit(0, 0, 18, 0, 12'h000, 0, 1);
        add_lit(0, 0, 20, 0, 12'h000, 0, 1);
        add_lit(0, 0, 21, 0, 12'h000, 1, 1);
        add_lit(0, 0, 0, 12, 12'h000, 1, 1);
        add_lit(0, 0, 0, 13, 12'h000, 1, 0);
        add_lit(0, 0, 0, 14, 12'h000, 1, 0);
        add_lit(0, 0, 0, 15, 12'h000, 1, 1);
        // Marker centre (5,4) half 1 in f00 over 00f.
        add_lit(0, 1, 4, 3, 12'hf00, 1, 1);
        add_lit(0, 1, 6, 5, 12'hf00, 1, 1);
        add_lit(0, 1, 5, 4, 12'hf00, 1, 1);
        add_lit(0, 1, 3, 4, 12'h00f, 1, 1);
        add_lit(0, 1, 7, 4, 12'h00f, 1, 1);
        add_lit(0, 1, 16, 4, 12'h000, 1, 1);
        // Switch colour takes over on the next frame.
        add_lit(0, 2, 5, 4, 12'h0f0, 1, 1);
        add_lit(0, 2, 4, 4, 12'h0f0, 1, 1);
        // posz=200 clamps to 3: columns 5..11, rows 3..9.
        add_lit(0, 3, 11, 9, 12'h0f0, 1, 1);
        add_lit(0, 3, 5, 3, 12'h0f0, 1, 1);
        add_lit(0, 3, 12, 6, 12'h00f, 1, 1);
        add_lit(0, 3, 4, 6, 12'h00f, 1, 1);
        add_lit(0, 3, 8, 10, 12'h00f, 1, 1);
        // Corner marker clipped, no wrap; posx change mid-frame does not show yet.
        add_lit(0, 4, 0, 0, 12'hf00, 1, 1);
        add_lit(0, 4, 3, 3, 12'hf00, 1, 1);
        add_lit(0, 4, 4, 0, 12'h00f, 1, 1);
        add_lit(0, 4, 0, 4, 12'h00f, 1, 1);
        add_lit(0, 4, 15, 11, 12'h00f, 1, 1);
        add_lit(0, 4, 15, 2, 12'h00f, 1, 1);
        add_lit(0, 4, 0, 11, 12'h00f, 1, 1);
        // New posx=15 from the next frame's (0,0).
        add_lit(0, 5, 12, 0, 12'hf00, 1, 1);
        add_lit(0, 5, 15, 3, 12'hf00, 1, 1);
        add_lit(0, 5, 11, 0, 12'h00f, 1, 1);
        add_lit(0, 5, 0, 0, 12'h00f, 1, 1);
        add_lit(0, 5, 15, 4, 12'h00f, 1, 1);
        // Centre far off-screen draws nothing.
        add_lit(0, 6, 15, 5, 12'h00f, 1, 1);
        add_lit(0, 6, 0, 5, 12'h00f, 1, 1);
        // After a mid-frame reset the reset shadows return.
        add_lit(1, 0, 0, 0, 12'h000, 1, 1);
        add_lit(1, 0, 1, 0, 12'h0c3, 1, 1);
        add_lit(1, 0, 15, 11, 12'h0c3, 1, 1);
        add_lit(1, 1, 15, 5, 12'h00f, 1, 1);
        foreach (lit_hit[i]) lit_hit[i] = 0;

        repeat (3) @(negedge HCLK);
        HRESET = 1'b0;

        wait_pix(0, 0, 2, 2);
        posx = 11'd5; posy = 11'd4; posz = 11'd1;
        point = 12'hf00; background = 12'h00f; sw_ctrl = 1'b0; sw = 12'h0f0;
        wait_pix(0, 1, 0, 1);
        sw_ctrl = 1'b1;
        wait_pix(0, 2, 0, 6);
        posx = 11'd8; posy = 11'd6; posz = 11'd200;
        wait_pix(0, 3, 0, 10);
        posx = 11'd0; posy = 11'd0; posz = 11'd3; sw_ctrl = 1'b0;
        wait_pix(0, 4, 0, 1);
        posx = 11'd15;
        wait_pix(0, 5, 0, 6);
        posx = 11'd1000; posy = 11'd5;
        wait_pix(0, 6, 5, 6);
        do_reset(3);
        wait_pix(1, 1, 15, 6);
        repeat (8) @(negedge HCLK);

        foreach (lits[i]) begin
            tests++;
            if (lit_hit[i] != 1) begin
                fails++;
                $display("FAIL literal visit e%0d f%0d (%0d,%0d): got %0d visits, want 1",
                         lits[i].ep, lits[i].f, lits[i].h, lits[i].v, lit_hit[i]);
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
